// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo_flex FIFO and its storage RAM.
package fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 8;
  localparam int unsigned DEF_ADDR_WIDTH    = 8;
  localparam int unsigned DEF_AEMPTY_THRESH = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Occupancy counter needs one extra bit so that DEPTH itself is representable.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic int unsigned def_afull_thresh(input int unsigned addr_width);
    return (32'd1 << addr_width) - 2;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module fifo_sdp_ram import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_we,
  input  logic [clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic                      i_re,
  input  logic [clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]     o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with thresholds, occupancy count, sticky error flags and flush.
// Define SYNC_FIFO_FLEX_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_flex import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned AFULL_THRESH  = def_afull_thresh(ADDR_WIDTH),
  parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_full,
  output logic                  o_wr_afull,
  output logic                  o_wr_overflow,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_empty,
  output logic                  o_rd_aempty,
  output logic                  o_rd_underflow,
  output logic [ADDR_WIDTH:0]   o_data_count
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
  localparam int unsigned CW    = cnt_width(ADDR_WIDTH);

  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] CNT_AEMPTY = CW'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_overflow;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_underflow;
  logic                  r_rd_valid;

  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [CW-1:0]         w_count_d;
  logic                  w_empty_d;
  logic                  w_valid_d;
  logic                  w_ram_we;
  logic                  w_ram_re;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // Acceptance is decided from the registered (pre-edge) flags only.
  assign w_wr_ok  = i_wr_en & ~r_full;
  assign w_rd_ok  = i_rd_en & ~r_empty;
  assign w_ram_we = w_wr_ok & ~i_clr;

  always_comb begin
    w_count_d = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

`ifdef SYNC_FIFO_FLEX_FWFT_EN
  // Two-stage prefetch: RAM output register (stage 1) feeds the output register (stage 2).
  logic [CW-1:0]         r_ram_cnt;
  logic                  r_s1;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  w_s2_load;
  logic [CW-1:0]         w_ram_cnt_d;

  always_comb begin
    w_s2_load   = r_s1 & (~r_rd_valid | w_rd_ok);
    w_ram_re    = (r_ram_cnt != '0) & (~r_s1 | w_s2_load) & ~i_clr;
    w_valid_d   = w_s2_load | (r_rd_valid & ~w_rd_ok);
    w_empty_d   = ~w_valid_d;
    w_ram_cnt_d = r_ram_cnt;
    case ({w_wr_ok, w_ram_re})
      2'b10:   w_ram_cnt_d = r_ram_cnt + CW'(1);
      2'b01:   w_ram_cnt_d = r_ram_cnt - CW'(1);
      default: w_ram_cnt_d = r_ram_cnt;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ram_cnt <= '0;
      r_s1      <= 1'b0;
      r_dout    <= '0;
    end else if (i_clr) begin
      r_ram_cnt <= '0;
      r_s1      <= 1'b0;
    end else begin
      r_ram_cnt <= w_ram_cnt_d;
      r_s1      <= w_ram_re | (r_s1 & ~w_s2_load);
      if (w_s2_load) r_dout <= w_ram_rdata;
    end
  end

  assign o_rd_data = r_dout;
`else
  always_comb begin
    w_ram_re  = w_rd_ok & ~i_clr;
    w_valid_d = w_rd_ok;
    w_empty_d = (w_count_d == '0);
  end

  assign o_rd_data = w_ram_rdata;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_afull     <= (CNT_AFULL == '0);
      r_overflow  <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_afull     <= (CNT_AFULL == '0);
      r_overflow  <= 1'b0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      if (w_wr_ok)  r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_ram_re) r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_count     <= w_count_d;
      r_full      <= (w_count_d == CNT_FULL);
      r_afull     <= (w_count_d >= CNT_AFULL);
      r_aempty    <= (w_count_d <= CNT_AEMPTY);
      r_empty     <= w_empty_d;
      r_rd_valid  <= w_valid_d;
      r_overflow  <= r_overflow | (i_wr_en & r_full);
      r_underflow <= r_underflow | (i_rd_en & r_empty);
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_wr_data),
    .i_re    (w_ram_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

  assign o_wr_full      = r_full;
  assign o_wr_afull     = r_afull;
  assign o_wr_overflow  = r_overflow;
  assign o_rd_valid     = r_rd_valid;
  assign o_rd_empty     = r_empty;
  assign o_rd_aempty    = r_aempty;
  assign o_rd_underflow = r_underflow;
  assign o_data_count   = r_count;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed, table-driven bench for sync_fifo_flex (depth 16, thresholds 14/2).
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       wr_full, wr_afull, wr_overflow;
  logic [7:0] rd_data;
  logic       rd_valid, rd_empty, rd_aempty, rd_underflow;
  logic [4:0] data_count;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       clr, wr, rd;
    logic [7:0] wd;
    logic [4:0] cnt;
    logic       em, fu, af, ae, ov, un, vl, ck;
    logic [7:0] rdd;
  } vec_t;

  vec_t vecs[$];

  sync_fifo_flex #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_clr          (clr),
    .i_wr_en        (wr_en),
    .i_wr_data      (wr_data),
    .o_wr_full      (wr_full),
    .o_wr_afull     (wr_afull),
    .o_wr_overflow  (wr_overflow),
    .i_rd_en        (rd_en),
    .o_rd_data      (rd_data),
    .o_rd_valid     (rd_valid),
    .o_rd_empty     (rd_empty),
    .o_rd_aempty    (rd_aempty),
    .o_rd_underflow (rd_underflow),
    .o_data_count   (data_count)
  );

  always #5 clk = ~clk;

  // Threshold flags follow from the hand-chosen count: full 16, afull >=14, aempty <=2.
  function automatic vec_t mk(input logic c, input logic w, input logic r, input logic [7:0] wd,
                              input int cnt, input logic em, input logic ov, input logic un,
                              input logic vl, input logic ck, input logic [7:0] rdd);
    vec_t v;
    v.clr = c; v.wr = w; v.rd = r; v.wd = wd;
    v.cnt = 5'(cnt);
    v.em = em; v.fu = (cnt == 16); v.af = (cnt >= 14); v.ae = (cnt <= 2);
    v.ov = ov; v.un = un; v.vl = vl; v.ck = ck; v.rdd = rdd;
    return v;
  endfunction

  function automatic logic [19:0] status();
    return {data_count, rd_empty, wr_full, wr_afull, rd_aempty, wr_overflow, rd_underflow,
            rd_valid, rd_data};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string name);
    logic [19:0] exp;
    logic [19:0] act;
    clr = v.clr; wr_en = v.wr; rd_en = v.rd; wr_data = v.wd;
    @(posedge clk);
    #1;
    act = status();
    exp = {v.cnt, v.em, v.fu, v.af, v.ae, v.ov, v.un, v.vl, v.rdd};
    if (!v.ck) act[7:0] = v.rdd;
    check(name, act, exp);
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_state", status(), {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    check("underflow_set", 20'(rd_underflow), 20'd1);
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + k);
      @(posedge clk);
      #1 wr_en = 1'b0;
      check("pre_rst_count", 20'(data_count), 20'(k + 1));
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset", status(), {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;

`ifdef SYNC_FIFO_FLEX_FWFT_EN
    vecs.push_back(mk(0, 1, 0, 8'h3C, 1, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 1, 0, 8'h11, 2, 0, 0, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 1, 0, 8'h22, 3, 0, 0, 0, 1, 1, 8'h3C));
    vecs.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 1, 1, 8'h11));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 8'h22));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 8'h00));
`else
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 1, 0, 8'(i), i + 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hEE, 16, 0, 1, 0, 0, 0, 8'h00));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(0, 0, 1, 8'h00, 15 - i, (i == 15), 1, 0, 1, 1, 8'(i)));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 1, 0, 1, 8'h0F));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 1, 0, 8'(8'h80 + k), k + 1, 0, 1, 1, 0, 0, 8'h00));
    for (int k = 0; k < 40; k++)
      vecs.push_back(mk(0, 1, 1, 8'(8'h88 + k), 8, 0, 1, 1, 1, 1, 8'(8'h80 + k)));
    vecs.push_back(mk(0, 1, 0, 8'hB0, 9, 0, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hB1, 10, 0, 1, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 1, 1, 8'h77, 0, 1, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 8'hA5, 1, 0, 0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 8'h5A, 1, 0, 0, 0, 1, 1, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 1, 8'h5A));
`endif

    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
